// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package pipeline_ctrl_pkg;

    localparam int REG_W           = 4;
    localparam int WAIT_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Writeback descriptor of a downstream stage, as seen by hazard detection.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
    } wb_src_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check of the ID sources against EXE/MEM destinations.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  wb_src_t          exe,
    input  wb_src_t          mem,
    input  logic             exe_mem_r_en,
    input  logic             forward_en,
    output logic             hazard
);

    logic hit_e, hit_m;

    assign hit_e = exe.wb_en & ((id_src1 == exe.dest) | (id_two_src & (id_src2 == exe.dest)));
    assign hit_m = mem.wb_en & ((id_src1 == mem.dest) | (id_two_src & (id_src2 == mem.dest)));

    // With forwarding, only a load in EXE cannot be bypassed in time.
    assign hazard = forward_en ? (hit_e & exe_mem_r_en) : (hit_e | hit_m);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush control: SRAM wait FSM, hazard/branch priority mux, stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              branch_taken,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_two_src,
    input  logic [REG_W-1:0]  exe_dest,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic              exe_wb_en,
    input  logic              mem_wb_en,
    input  logic              exe_mem_r_en,
    input  logic              forward_en,
    input  logic              stat_clr,
    output logic              pc_freeze,
    output logic              if_freeze,
    output logic              if_flush,
    output logic              id_flush,
    output logic              pipe_freeze,
    output logic              mem_ready,
    output logic [STAT_W-1:0] stall_count
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       mem_req, mem_stall, hazard;

    assign mem_req = mem_r_en | mem_w_en;

    hazard_detect u_hazard (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe          ('{dest: exe_dest, wb_en: exe_wb_en}),
        .mem          ('{dest: mem_dest, wb_en: mem_wb_en}),
        .exe_mem_r_en (exe_mem_r_en),
        .forward_en   (forward_en),
        .hazard       (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Stall is Mealy in IDLE so the requesting cycle itself is frozen.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mem_stall = 1'b0;
        mem_ready = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    mem_stall = 1'b1;
                    state_nx  = BUSY;
                    cnt_nx    = CNT_INIT;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (cnt == 4'd0) state_nx = DONE;
                else             cnt_nx   = cnt - 4'd1;
            end
            DONE: begin
                // Request still visible here belongs to the access being retired.
                mem_ready = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pc_freeze   = 1'b0;
        if_freeze   = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_stall) begin
            pc_freeze   = 1'b1;
            if_freeze   = 1'b1;
            pipe_freeze = 1'b1;
        end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (hazard) begin
            pc_freeze = 1'b1;
            if_freeze = 1'b1;
            id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          stall_count <= '0;
        else if (stat_clr)                stall_count <= '0;
        else if (pc_freeze && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for the priority mux plus FSM/counter sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en, branch_taken;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_two_src, exe_wb_en, mem_wb_en, exe_mem_r_en, forward_en, stat_clr;
    logic        pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_ready;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_CYCLES(4), .STAT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch_taken(branch_taken),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .mem_dest(mem_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .forward_en(forward_en), .stat_clr(stat_clr),
        .pc_freeze(pc_freeze), .if_freeze(if_freeze), .if_flush(if_flush),
        .id_flush(id_flush), .pipe_freeze(pipe_freeze), .mem_ready(mem_ready),
        .stall_count(stall_count)
    );

    // exp = {pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze}
    typedef struct {
        logic       mr, mw, br;
        logic [3:0] s1, s2;
        logic       two;
        logic [3:0] ed, md;
        logic       ewb, mwb, emr, fwd;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        mem_r_en = 0; mem_w_en = 0; branch_taken = 0;
        id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; mem_dest = 0; exe_wb_en = 0; mem_wb_en = 0;
        exe_mem_r_en = 0; forward_en = 0; stat_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          mr mw br s1 s2 two ed md ewb mwb emr fwd exp
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000};
        vecs[1]  = '{0, 0, 0, 3, 0, 0, 3, 0, 1, 0, 0, 0, 5'b11010};
        vecs[2]  = '{0, 0, 0, 3, 0, 0, 3, 0, 1, 0, 0, 1, 5'b00000};
        vecs[3]  = '{0, 0, 0, 3, 0, 0, 3, 0, 1, 0, 1, 1, 5'b11010};
        vecs[4]  = '{0, 0, 0, 1, 3, 0, 3, 0, 1, 0, 0, 0, 5'b00000};
        vecs[5]  = '{0, 0, 0, 1, 3, 1, 3, 0, 1, 0, 0, 0, 5'b11010};
        vecs[6]  = '{0, 0, 0, 5, 0, 0, 9, 5, 0, 1, 0, 0, 5'b11010};
        vecs[7]  = '{0, 0, 0, 5, 0, 0, 9, 5, 0, 1, 0, 1, 5'b00000};
        vecs[8]  = '{0, 0, 0, 3, 0, 0, 3, 3, 0, 0, 0, 0, 5'b00000};
        vecs[9]  = '{0, 0, 1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 5'b00110};
        vecs[10] = '{0, 1, 1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 5'b11001};
        vecs[11] = '{0, 0, 1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 5'b00110};
        vecs[12] = '{1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 5'b11001};
        vecs[13] = '{0, 0, 0, 2, 6, 1, 6, 0, 1, 0, 1, 1, 5'b11010};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11010};

        clear_inputs();
        rst = 1'b1;
        #3;
        check("reset_stall_count", 32'(stall_count), 0);
        check("reset_mem_ready", 32'(mem_ready), 0);
        check("reset_outputs", 32'({pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze}), 0);
        tick();
        rst = 1'b0;

        // Memory-request vectors run under reset so the FSM stays in IDLE.
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].mr | vecs[i].mw;
            mem_r_en = vecs[i].mr; mem_w_en = vecs[i].mw; branch_taken = vecs[i].br;
            id_src1 = vecs[i].s1; id_src2 = vecs[i].s2; id_two_src = vecs[i].two;
            exe_dest = vecs[i].ed; mem_dest = vecs[i].md;
            exe_wb_en = vecs[i].ewb; mem_wb_en = vecs[i].mwb;
            exe_mem_r_en = vecs[i].emr; forward_en = vecs[i].fwd;
            #1;
            check($sformatf("vec%0d_outputs", i),
                  32'({pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze}), 32'(vecs[i].exp));
            check($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 0);
        end
        clear_inputs();
        do_reset();

        // Request held from cycle 0; a request seen in DONE must not restart the access.
        tick();
        mem_r_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #2;
            check($sformatf("held_c%0d_pipe_freeze", c), 32'(pipe_freeze),
                  32'((c <= 4) || (c >= 6 && c <= 10)));
            check($sformatf("held_c%0d_mem_ready", c), 32'(mem_ready), 32'(c == 5 || c == 11));
            if (c == 6) check("held_stall_count", 32'(stall_count), 5);
            tick();
        end
        clear_inputs();
        do_reset();

        // Extra request during BUSY must not alter timing.
        tick();
        for (int c = 0; c < 7; c++) begin
            mem_w_en = (c == 0);
            mem_r_en = (c == 3);
            #2;
            check($sformatf("busyreq_c%0d_pipe_freeze", c), 32'(pipe_freeze), 32'(c <= 4));
            check($sformatf("busyreq_c%0d_mem_ready", c), 32'(mem_ready), 32'(c == 5));
            tick();
        end
        clear_inputs();
        do_reset();

        // Reset in the second BUSY cycle aborts the access.
        tick();
        mem_r_en = 1'b1;
        tick();
        mem_r_en = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_stall_count", 32'(stall_count), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #2;
            check($sformatf("abort_c%0d_mem_ready", c), 32'(mem_ready), 0);
            check($sformatf("abort_c%0d_pipe_freeze", c), 32'(pipe_freeze), 0);
            tick();
        end
        check("abort_stall_count_after", 32'(stall_count), 0);

        // Saturation: hazard stall held to reach FFFE, then 3 more cycles.
        do_reset();
        exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3;
        #1;
        check("sat_hazard_freeze", 32'(pc_freeze), 1);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(stall_count), 32'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_ffff", 32'(stall_count), 32'hFFFF);
        stat_clr = 1'b1;
        tick();
        check("clr_wins", 32'(stall_count), 0);
        stat_clr = 1'b0;
        tick();
        check("count_after_clr", 32'(stall_count), 1);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4, SRAM access wait cycles (legal range 1..15).
REQ-002 SHALL have parameter STAT_W, default 16, stall counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports mem_r_en, mem_w_en  input  1 each  MEM-stage load/store request.
REQ-006 SHALL have port branch_taken  input  1  EXE-stage branch resolved taken.
REQ-007 SHALL have ports id_src1, id_src2  input  4 each  ID-stage source register numbers.
REQ-008 SHALL have port id_two_src  input  1  ID instruction reads id_src2.
REQ-009 SHALL have ports exe_dest, mem_dest  input  4 each; exe_wb_en, mem_wb_en, exe_mem_r_en  input  1 each.
REQ-010 SHALL have port forward_en  input  1  forwarding unit active.
REQ-011 SHALL have port stat_clr  input  1  synchronous clear of stall_count.
REQ-012 SHALL have outputs pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_ready  1 each; stall_count  STAT_W.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE with a 4-bit down-counter cnt.
REQ-014 IDLE: on (mem_r_en | mem_w_en), next state BUSY and cnt <= WAIT_CYCLES-1; otherwise stay in IDLE.
REQ-015 BUSY: if cnt==0, next state DONE; otherwise cnt <= cnt-1.
REQ-016 DONE: mem_ready=1 for exactly one cycle; next state is IDLE unconditionally; a request visible in DONE SHALL be ignored, because it is the one being retired.
REQ-017 mem_stall = (IDLE & request) | BUSY (Mealy); a request in cycle T gives mem_stall high for cycles T..T+WAIT_CYCLES and mem_ready in cycle T+WAIT_CYCLES+1.
REQ-018 Data hazard: hit_e = exe_wb_en & (id_src1==exe_dest | (id_two_src & id_src2==exe_dest)); hit_m is the same with mem_wb_en/mem_dest.
REQ-019 hazard = forward_en ? (hit_e & exe_mem_r_en) : (hit_e | hit_m).
REQ-020 Priority 1, mem_stall=1: pc_freeze=if_freeze=pipe_freeze=1, if_flush=id_flush=0, and branch_taken/hazard ignored.
REQ-021 Priority 2, branch_taken=1: if_flush=id_flush=1, pc_freeze=if_freeze=pipe_freeze=0.
REQ-022 Priority 3, hazard=1: pc_freeze=if_freeze=1, id_flush=1 (bubble), if_flush=pipe_freeze=0.
REQ-023 With none of the three conditions active, all freeze/flush outputs SHALL be 0.
REQ-024 All freeze/flush outputs SHALL be combinational from current state and inputs, with no added latency.
REQ-025 stall_count SHALL increment each cycle pc_freeze=1, saturate at all-ones, and load 0 on stat_clr; stat_clr wins over an increment in the same cycle.
REQ-026 A request arriving while in BUSY SHALL have no effect on the FSM.

Reset
REQ-027 rst=1 SHALL force state IDLE, cnt=0 and stall_count=0 asynchronously.
REQ-028 During reset, mem_ready=0 and the freeze/flush outputs SHALL follow REQ-020..023 for state IDLE.
REQ-029 Reset asserted mid-BUSY SHALL abort the access; the FSM SHALL not pass through DONE and mem_ready SHALL stay 0.

Structure
REQ-030 Package pipeline_ctrl_pkg SHALL hold the state enum, REG_W=4 and the default WAIT_CYCLES constant.
REQ-031 Data hazard logic (REQ-018..019) SHALL be a combinational sub-module hazard_detect.
REQ-032 The FSM, the priority mux and stall_count SHALL reside in pipeline_ctrl.

Verification
REQ-033 WAIT_CYCLES=4, mem_r_en held high from cycle 0 -> pipe_freeze=1 in cycles 0..4, mem_ready=1 in cycle 5, mem_ready=0 in cycle 6, stall_count=5.
REQ-034 forward_en=0, exe_wb_en=1, exe_dest=3, id_src1=3 -> pc_freeze=1, if_freeze=1, id_flush=1, if_flush=0.
REQ-035 forward_en=1, same as REQ-034 with exe_mem_r_en=0 -> all outputs 0; with exe_mem_r_en=1 -> hazard stall.
REQ-036 branch_taken=1 together with a hazard -> if_flush=id_flush=1, pc_freeze=0; adding mem_w_en=1 -> freeze outputs only.
REQ-037 rst pulsed in the 2nd BUSY cycle -> state IDLE, mem_ready never asserted, stall_count=0.
REQ-038 stall_count preloaded to 16'hFFFE by stalling, then 3 stall cycles -> holds 16'hFFFF; stat_clr plus a stall in the same cycle -> 0.
